dense_layer_param: RTL and testbench

DENSE_LAYER_PARAM -- requirements
Module: dense_layer_param

---
 rtl/dense_layer_param.sv | 215 +++++++++++++++++++++
 tb/tb_dense_layer_param.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_layer_param.sv
// Streaming fully-connected layer: one sample per cycle against a weight ROM,
// NUM_NEURONS parallel MACs, rounded and saturated Q-format results.
module single_port_rom #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter logic [WIDTH*DEPTH-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] data_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_word
    assign mem[k] = INIT[k*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    data_q <= (32'(addr_i) < DEPTH) ? mem[addr_i] : '0;
  end

  assign data_o = data_q;

endmodule

module dense_layer_param #(
  parameter int NUM_NEURONS = 10,
  parameter int NUM_INPUTS  = 256,
  parameter int DATA_W      = 16,
  parameter int FRAC_W      = 8,
  localparam int ADDR_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  parameter int ACC_W       = 2*DATA_W + ADDR_W,
  parameter logic [NUM_INPUTS*NUM_NEURONS*DATA_W-1:0] WEIGHTS =
    {(NUM_INPUTS*NUM_NEURONS){DATA_W'(1 << FRAC_W)}}
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          frame_start_in,
  input  logic                          frame_end_in,
  input  logic [DATA_W-1:0]             dense_input,
  input  logic [NUM_NEURONS*DATA_W-1:0] bias_in,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [NUM_NEURONS*DATA_W-1:0] dense_sum_out,
  output logic                          err_len,
  output logic                          err_ovf
);

  localparam int CNT_W = $clog2(NUM_INPUTS + 1);
  localparam int ROW_W = NUM_NEURONS * DATA_W;
  localparam int T_W   = ACC_W + 2;

  localparam logic signed [T_W-1:0] MAXV =
    {{(T_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [T_W-1:0] MINV =
    {{(T_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [T_W-1:0] RND =
    T_W'(1) << (FRAC_W - 1);

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             over_q, over_d;

  logic s1_acc_q, s1_acc_d;
  logic s1_first_q, s1_first_d;
  logic s1_end_q, s1_end_d;
  logic s1_err_q, s1_err_d;
  logic [DATA_W-1:0] s1_x_q;

  logic [ADDR_W-1:0] rom_addr;
  logic [ROW_W-1:0]  rom_q;

  logic fin_q, fin_err_q;

  logic [ROW_W-1:0] res;
  logic [ROW_W-1:0] out_q;
  logic             valid_q, err_len_q, err_ovf_q;

  single_port_rom #(
    .WIDTH (ROW_W),
    .DEPTH (NUM_INPUTS),
    .AW    (ADDR_W),
    .INIT  (WEIGHTS)
  ) u_rom (
    .clk    (clk),
    .addr_i (rom_addr),
    .data_o (rom_q)
  );

  // Frame tracking; decides per sample whether it loads, adds or is dropped
  always_comb begin
    active_d   = active_q;
    cnt_d      = cnt_q;
    over_d     = over_q;
    s1_acc_d   = 1'b0;
    s1_first_d = 1'b0;
    s1_end_d   = 1'b0;
    s1_err_d   = 1'b0;
    rom_addr   = cnt_q[ADDR_W-1:0];
    if (ena) begin
      if (frame_start_in) begin
        rom_addr   = '0;
        s1_acc_d   = 1'b1;
        s1_first_d = 1'b1;
        cnt_d      = CNT_W'(1);
        over_d     = 1'b0;
        active_d   = !frame_end_in;
        s1_end_d   = frame_end_in;
        s1_err_d   = (NUM_INPUTS != 1);
      end else if (active_q) begin
        if (cnt_q < CNT_W'(NUM_INPUTS)) begin
          s1_acc_d = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end else begin
          over_d = 1'b1;
        end
        if (frame_end_in) begin
          active_d = 1'b0;
          s1_end_d = 1'b1;
          s1_err_d = over_d || (cnt_d != CNT_W'(NUM_INPUTS));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      cnt_q      <= '0;
      over_q     <= 1'b0;
      s1_acc_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_end_q   <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_x_q     <= '0;
      fin_q      <= 1'b0;
      fin_err_q  <= 1'b0;
    end else begin
      active_q   <= active_d;
      cnt_q      <= cnt_d;
      over_q     <= over_d;
      s1_acc_q   <= s1_acc_d;
      s1_first_q <= s1_first_d;
      s1_end_q   <= s1_end_d;
      s1_err_q   <= s1_err_d;
      s1_x_q     <= dense_input;
      fin_q      <= s1_end_q;
      fin_err_q  <= s1_err_q;
    end
  end

  for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_n
    logic signed [DATA_W-1:0]   w;
    logic signed [DATA_W-1:0]   x;
    logic signed [DATA_W-1:0]   b;
    logic signed [2*DATA_W-1:0] mul;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [T_W-1:0]      t;
    logic signed [T_W-1:0]      r;

    assign w   = $signed(rom_q[i*DATA_W +: DATA_W]);
    assign x   = $signed(s1_x_q);
    assign b   = $signed(bias_in[i*DATA_W +: DATA_W]);
    assign mul = (2*DATA_W)'(w) * (2*DATA_W)'(x);

    assign acc_d = s1_first_q ? ACC_W'(mul)
                              : acc_q + ACC_W'(mul);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        acc_q <= '0;
      end else if (s1_acc_q) begin
        acc_q <= acc_d;
      end
    end

    // Round half up, then clamp to the signed DATA_W range
    assign t = T_W'(acc_q) + (T_W'(b) <<< FRAC_W) + RND;
    assign r = t >>> FRAC_W;

    assign res[i*DATA_W +: DATA_W] =
      (r > MAXV) ? MAXV[DATA_W-1:0] :
      (r < MINV) ? MINV[DATA_W-1:0] :
                   r[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      out_q     <= '0;
      err_len_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      err_ovf_q <= 1'b0;
      if (fin_q) begin
        out_q     <= res;
        err_len_q <= fin_err_q;
        valid_q   <= 1'b1;
        err_ovf_q <= valid_q & ~out_ready;
      end else if (valid_q & out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid     = valid_q;
  assign dense_sum_out = out_q;
  assign err_len       = err_len_q;
  assign err_ovf       = err_ovf_q;

endmodule

// File: tb/tb_dense_layer_param.sv
// Directed bench for dense_layer_param: unit weights (u_a) and
// 0x7FFF weights (u_b) share one stimulus stream.
module tb_dense_layer_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        fs;
  logic        fe;
  logic [15:0] din;
  logic [31:0] bias;
  logic        out_ready;

  logic        ov_a, el_a, eo_a;
  logic [31:0] d_a;
  logic        ov_b, el_b, eo_b;
  logic [31:0] d_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dense_layer_param #(
    .NUM_NEURONS (2),
    .NUM_INPUTS  (4),
    .DATA_W      (16),
    .FRAC_W      (8)
  ) u_a (
    .clk            (clk),
    .rst_n          (rst_n),
    .ena            (ena),
    .frame_start_in (fs),
    .frame_end_in   (fe),
    .dense_input    (din),
    .bias_in        (bias),
    .out_ready      (out_ready),
    .out_valid      (ov_a),
    .dense_sum_out  (d_a),
    .err_len        (el_a),
    .err_ovf        (eo_a)
  );

  dense_layer_param #(
    .NUM_NEURONS (2),
    .NUM_INPUTS  (4),
    .DATA_W      (16),
    .FRAC_W      (8),
    .WEIGHTS     ({8{16'h7FFF}})
  ) u_b (
    .clk            (clk),
    .rst_n          (rst_n),
    .ena            (ena),
    .frame_start_in (fs),
    .frame_end_in   (fe),
    .dense_input    (din),
    .bias_in        (bias),
    .out_ready      (out_ready),
    .out_valid      (ov_b),
    .dense_sum_out  (d_b),
    .err_len        (el_b),
    .err_ovf        (eo_b)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(input logic e, input logic s,
                      input logic f, input logic [15:0] d);
    ena = e;
    fs  = s;
    fe  = f;
    din = d;
    @(posedge clk);
    #1;
    ena = 1'b0;
    fs  = 1'b0;
    fe  = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic frame4(input logic [15:0] d);
    step(1'b1, 1'b1, 1'b0, d);
    step(1'b1, 1'b0, 1'b0, d);
    step(1'b1, 1'b0, 1'b0, d);
    step(1'b1, 1'b0, 1'b1, d);
  endtask

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b0;
    fs        = 1'b0;
    fe        = 1'b0;
    din       = '0;
    bias      = '0;
    out_ready = 1'b1;
    idle();
    idle();
    check("rst_valid", 32'(ov_a), 32'd0);
    check("rst_data",  d_a,       32'h0);
    check("rst_len",   32'(el_a), 32'd0);
    check("rst_ovf",   32'(eo_a), 32'd0);
    rst_n = 1'b1;
    idle();

    // basic frame and latency
    frame4(16'h0100);
    idle();
    check("lat_e1_valid", 32'(ov_a), 32'd0);
    idle();
    check("lat_e2_valid", 32'(ov_a), 32'd1);
    check("basic_data",   d_a,       32'h0400_0400);
    check("basic_len",    32'(el_a), 32'd0);
    idle();
    check("hs_drop", 32'(ov_a), 32'd0);

    // per-neuron bias
    bias = 32'hFF00_0100;
    frame4(16'h0100);
    idle();
    idle();
    check("bias_data", d_a, 32'h0300_0500);
    bias = '0;
    idle();

    // saturation on both rails
    frame4(16'h7FFF);
    idle();
    idle();
    check("sat_pos_b", d_b, 32'h7FFF_7FFF);
    check("sat_pos_a", d_a, 32'h7FFF_7FFF);
    frame4(16'h8000);
    idle();
    idle();
    check("sat_neg_b", d_b, 32'h8000_8000);
    check("sat_neg_a", d_a, 32'h8000_8000);

    // rounding
    frame4(16'h0001);
    idle();
    idle();
    check("rnd_pos_b", d_b, 32'h0200_0200);
    check("rnd_pos_a", d_a, 32'h0004_0004);
    frame4(16'hFFFF);
    idle();
    idle();
    check("rnd_neg_b", d_b, 32'hFE00_FE00);
    check("rnd_neg_a", d_a, 32'hFFFC_FFFC);

    // short frame
    step(1'b1, 1'b1, 1'b0, 16'h0100);
    step(1'b1, 1'b0, 1'b0, 16'h0100);
    step(1'b1, 1'b0, 1'b1, 16'h0100);
    idle();
    idle();
    check("short_valid", 32'(ov_a), 32'd1);
    check("short_len",   32'(el_a), 32'd1);
    check("short_data",  d_a,       32'h0300_0300);

    // long frame: extra samples dropped
    step(1'b1, 1'b1, 1'b0, 16'h0100);
    step(1'b1, 1'b0, 1'b0, 16'h0100);
    step(1'b1, 1'b0, 1'b0, 16'h0100);
    step(1'b1, 1'b0, 1'b0, 16'h0100);
    step(1'b1, 1'b0, 1'b0, 16'h7FFF);
    step(1'b1, 1'b0, 1'b1, 16'h7FFF);
    idle();
    idle();
    check("long_len",  32'(el_a), 32'd1);
    check("long_data", d_a,       32'h0400_0400);

    // one-sample frame
    step(1'b1, 1'b1, 1'b1, 16'h0100);
    idle();
    idle();
    check("one_valid", 32'(ov_a), 32'd1);
    check("one_data",  d_a,       32'h0100_0100);
    check("one_len",   32'(el_a), 32'd1);

    // samples outside a frame are ignored
    idle();
    step(1'b1, 1'b0, 1'b0, 16'h7FFF);
    step(1'b1, 1'b0, 1'b0, 16'h7FFF);
    step(1'b1, 1'b0, 1'b1, 16'h7FFF);
    idle();
    idle();
    idle();
    check("stray_none", 32'(ov_a), 32'd0);
    frame4(16'h0100);
    idle();
    idle();
    check("stray_data", d_a,       32'h0400_0400);
    check("stray_len",  32'(el_a), 32'd0);

    // overwrite of unread result
    out_ready = 1'b0;
    frame4(16'h0100);
    frame4(16'h0200);
    idle();
    check("ovf_old_data",  d_a,       32'h0400_0400);
    check("ovf_old_pulse", 32'(eo_a), 32'd0);
    idle();
    check("ovf_new_data",  d_a,       32'h0800_0800);
    check("ovf_pulse",     32'(eo_a), 32'd1);
    check("ovf_valid",     32'(ov_a), 32'd1);
    idle();
    check("ovf_pulse_end", 32'(eo_a), 32'd0);
    check("ovf_hold",      32'(ov_a), 32'd1);
    out_ready = 1'b1;
    idle();
    check("ovf_release", 32'(ov_a), 32'd0);

    // new result on the handshake edge
    out_ready = 1'b0;
    frame4(16'h0100);
    idle();
    idle();
    frame4(16'h0200);
    idle();
    out_ready = 1'b1;
    idle();
    check("same_valid", 32'(ov_a), 32'd1);
    check("same_ovf",   32'(eo_a), 32'd0);
    check("same_data",  d_a,       32'h0800_0800);
    idle();
    check("same_drop", 32'(ov_a), 32'd0);

    // reset in the middle of a frame
    out_ready = 1'b0;
    frame4(16'h0100);
    idle();
    idle();
    step(1'b1, 1'b1, 1'b0, 16'h7FFF);
    step(1'b1, 1'b0, 1'b0, 16'h7FFF);
    rst_n = 1'b0;
    idle();
    check("mrst_valid", 32'(ov_a), 32'd0);
    check("mrst_data",  d_a,       32'h0);
    check("mrst_len",   32'(el_a), 32'd0);
    check("mrst_ovf",   32'(eo_a), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    frame4(16'h0100);
    idle();
    idle();
    check("mrst_after", d_a,       32'h0400_0400);
    check("mrst_alen",  32'(el_a), 32'd0);

    // restart abandons the partial frame
    idle();
    step(1'b1, 1'b1, 1'b0, 16'h7FFF);
    step(1'b1, 1'b0, 1'b0, 16'h7FFF);
    frame4(16'h0100);
    idle();
    check("rs_none",  32'(ov_a), 32'd0);
    idle();
    check("rs_valid", 32'(ov_a), 32'd1);
    check("rs_data",  d_a,       32'h0400_0400);
    check("rs_len",   32'(el_a), 32'd0);
    idle();
    check("rs_single", 32'(ov_a), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
